rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as a bus port or one encoder/decoder datapath instance, among four clients. It issues a registered one-hot grant plus the matching 2-bit encoded index, holds the grant while the owner keeps requesting, and hands off fairly using a rotating priority pointer. A hold-time limit pre-empts an owner that starves other requesters. It sits between the client request lines and the shared resource's enable/select inputs.

## Interface
- HOLD_MAX, default 8: maximum consecutive grant cycles for one owner while any other request is pending; legal range 2..255.
- CNT_W, default 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbiter enable; low forces release of any grant
- req  in  4  request vector, bit i = client i; level-sensitive
- gnt  out  4  registered one-hot grant; 4'b0000 when no owner
- gnt_idx  out  2  encoded index of the owner; 2'd0 when gnt_valid = 0
- gnt_valid  out  1  high while any grant is active (equals |gnt)
- preempt  out  1  one-cycle pulse in the cycle the grant changes owner because of HOLD_MAX

## Operation
- States: IDLE (no owner) and BUSY (owner = gnt_idx).
- Pick function: search order is last+1, last+2, last+3, last, all modulo 4; first set bit wins. "last" is the most recent owner and resets to 3, so req0 has top priority after reset.
- IDLE: if en=1 and req≠0, register the pick, go to BUSY, set last = pick, clear hold_cnt. Otherwise stay in IDLE with outputs at 0.
- BUSY, owner o:
  - en=0: go to IDLE next edge, gnt=0; last is unchanged.
  - req[o]=0 (release): pick among req with bit o masked. If nonzero, hand off directly to BUSY with the new owner, with no idle bubble. If zero, go to IDLE.
  - req[o]=1 and hold_cnt = HOLD_MAX-1 and (req & ~onehot(o)) ≠ 0: pre-empt. Grant the masked pick, pulse preempt, clear hold_cnt.
  - req[o]=1, otherwise: keep the owner. hold_cnt increments and saturates at HOLD_MAX-1 while no other request is pending, so the owner keeps the grant indefinitely when alone.
- Each owner change sets last to the new owner and clears hold_cnt.
- Simultaneous release and pre-empt: treated as a release, with preempt = 0.
- Request dropped by a non-owner: no effect.
- The grant is never given to a client whose req is low in the cycle the decision is made.

## Timing
- Reset (asynchronous, immediate): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, last=3, hold_cnt=0. Reset is allowed mid-grant; outputs drop without waiting for a clock edge.
- Latency: a req sampled at edge n in IDLE produces gnt at edge n+1, one cycle later.
- Handoff: if the owner drops req before edge n, the new gnt is visible after edge n. Zero idle cycles.
- Pre-empt: the owner holds for exactly HOLD_MAX cycles, then the new owner appears on the next edge, with preempt high for that one cycle.
- All outputs are registered with no combinational path from req to gnt.
- en deasserted: gnt=0 after the next edge.

## Structure
- Shared package arb_pkg contains:
  - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1;
  - N_REQ=4 and IDX_W=2;
  - the onehot/index conversion functions, the same mapping as the 2-to-4 decoder and 4-to-2 encoder.
- Sub-module rr_pick4 is purely combinational. Inputs: req[3:0], last[1:0]. Outputs: pick_idx[1:0], pick_valid. It rotates req by last+1, applies a fixed-priority encode, then rotates the index back. It is instantiated once, fed with either raw or owner-masked req.
- The top contains the state register, last pointer, hold counter and output registers.

## Test plan
- Reset then req=4'b1111: grants cycle 0,1,2,3,0 with gnt_idx 0→1→2→3→0, HOLD_MAX=8, each owner held 8 cycles, preempt pulsing at each change.
- req=4'b0100 alone for 20 cycles: gnt=4'b0100 throughout, preempt never pulses, hold_cnt saturates.
- Owner 1 active, req=4'b1010; owner drops bit 1: next edge gnt=4'b1000, gnt_idx=3, no cycle with gnt_valid=0.
- BUSY owner 2, en dropped: gnt=0 after one edge. en raised with req=4'b0101: grant goes to 0, not 2, because last=2.
- rst_n asserted mid-grant, between edges: gnt, gnt_idx and gnt_valid go to 0 immediately. After release with req=4'b1000, gnt=4'b1000 one edge later.
- Owner 0 releases in the same cycle its hold limit would fire, with req1 pending: owner 1 is granted and preempt stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Index to one-hot, same mapping as a 2-to-4 decoder.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // One-hot to index, same mapping as a 4-to-2 encoder.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request searching from last+1.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [IDX_W-1:0] base;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] lowest;

    assign base = last + IDX_W'(1);

    // Rotate so that bit 0 of rot is the client right after last.
    always_comb begin
        logic [IDX_W-1:0] src;
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            src    = IDX_W'(i) + base;
            rot[i] = req[src];
        end
    end

    assign lowest     = rot & (~rot + ONE);
    assign pick_idx   = onehot2idx(lowest) + base;
    assign pick_valid = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with hold-time pre-emption.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

    logic             state, state_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             preempt_nxt;
    logic [N_REQ-1:0] gnt_nxt;

    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    // The current owner is masked out while busy so a pick is always a new owner.
    assign pick_req = (state == ST_BUSY) ? (req & ~idx2onehot(gnt_idx)) : req;

    rr_pick4 u_pick (
        .req        (pick_req),
        .last       (last),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // State, rotation pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= IDX_W'(N_REQ - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next owner decision: acquire, release/handoff, pre-empt or hold.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = gnt_idx;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        if (state == ST_IDLE) begin
            idx_nxt  = '0;
            hold_nxt = '0;
            if (en && pick_valid) begin
                state_nxt = ST_BUSY;
                idx_nxt   = pick_idx;
                last_nxt  = pick_idx;
            end
        end else begin
            if (!en) begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
                hold_nxt  = '0;
            end else if (!req[gnt_idx]) begin
                hold_nxt = '0;
                if (pick_valid) begin
                    idx_nxt  = pick_idx;
                    last_nxt = pick_idx;
                end else begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end
            end else if (hold_cnt == HOLD_LIM && pick_valid) begin
                idx_nxt     = pick_idx;
                last_nxt    = pick_idx;
                hold_nxt    = '0;
                preempt_nxt = 1'b1;
            end else if (hold_cnt != HOLD_LIM) begin
                hold_nxt = hold_cnt + CNT_W'(1);
            end
        end
    end

    // Grant vector for the next cycle.
    always_comb begin
        gnt_nxt = '0;
        if (state_nxt == ST_BUSY) gnt_nxt = idx2onehot(idx_nxt);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            gnt_idx <= '0;
            preempt <= 1'b0;
        end else begin
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            preempt <= preempt_nxt;
        end
    end

    assign gnt_valid = (state == ST_BUSY);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (-1 = none), last owner, cycles the owner has held the grant.
    int   m_owner;
    int   m_last;
    int   m_held;
    logic m_pre;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       pre;
    } vec_t;

    vec_t tbl[10];

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] r, int lst, int excl);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (lst + k) % 4;
            if (i != excl && r[2'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step();
        int p;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            if (en && req != 4'b0000) begin
                p = pick(req, m_last, -1);
                m_owner = p; m_last = p; m_held = 1;
            end
        end else if (!en) begin
            m_owner = -1;
        end else if (!req[2'(m_owner)]) begin
            p = pick(req, m_last, m_owner);
            m_owner = p;
            if (p >= 0) begin m_last = p; m_held = 1; end
        end else if (m_held >= HOLD_MAX && pick(req, m_last, m_owner) >= 0) begin
            p = pick(req, m_last, m_owner);
            m_owner = p; m_last = p; m_held = 1; m_pre = 1'b1;
        end else if (m_held < HOLD_MAX) begin
            m_held++;
        end
    endtask

    task automatic check(string name, logic [3:0] eg, logic [1:0] ei, logic ev, logic ep);
        checks++;
        if ({gnt, gnt_idx, gnt_valid, preempt} !== {eg, ei, ev, ep}) begin
            failures++;
            $display("FAIL %s t=%0t: gnt=%b idx=%0d valid=%b preempt=%b, expected gnt=%b idx=%0d valid=%b preempt=%b",
                     name, $time, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
        end
    endtask

    task automatic check_model(string name);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = 4'b0000;
        ei = 2'd0;
        if (m_owner >= 0) begin
            eg = 4'b0001;
            eg = eg << m_owner;
            ei = 2'(m_owner);
        end
        check(name, eg, ei, (m_owner >= 0), m_pre);
    endtask

    // Drive inputs away from the edge, clock once, update model, sample after the edge.
    task automatic step(logic e, logic [3:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        req   = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic       e;
        int         idx;
        logic       pre;

        tbl[0] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0};
        tbl[3] = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0};
        tbl[4] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0};
        tbl[5] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[6] = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 4'b0101, 4'b0000, 2'd0, 1'b0};
        tbl[8] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0};
        tbl[9] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};

        #2;
        do_reset();

        // Table-driven vectors from reset.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].req);
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].idx, |tbl[i].gnt, tbl[i].pre);
        end

        // All four requesting: each owner holds HOLD_MAX cycles, then rotates with a preempt pulse.
        do_reset();
        for (int c = 1; c <= 4 * HOLD_MAX + 2; c++) begin
            step(1'b1, 4'b1111);
            idx = ((c - 1) / HOLD_MAX) % 4;
            pre = (c > 1 && ((c - 1) % HOLD_MAX) == 0);
            r   = 4'b0001;
            r   = r << idx;
            check($sformatf("rotate_c%0d", c), r, 2'(idx), 1'b1, pre);
        end

        // Lone requester keeps the grant indefinitely.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 4'b0100);
            check("lone_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end

        // Release by owner 1 hands straight to 3 with no idle bubble.
        do_reset();
        step(1'b1, 4'b0010);
        check("own1_acquire", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b1, 4'b1010);
        check("own1_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b1, 4'b1000);
        check("handoff_to3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Enable drop releases; re-enable picks after last=2.
        do_reset();
        step(1'b1, 4'b0100);
        check("own2_acquire", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 4'b0100);
        check("en_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0101);
        check("en_reacquire", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges drops outputs immediately.
        do_reset();
        step(1'b1, 4'b0010);
        check("pre_async_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b1000);
        check("post_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Release coinciding with the hold limit counts as release, no preempt.
        do_reset();
        for (int c = 0; c < HOLD_MAX; c++) step(1'b1, 4'b0011);
        check("limit_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b1, 4'b0010);
        check("release_at_limit", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Randomized sticky requests against the reference model.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            e = ($urandom_range(0, 19) != 0);
            step(e, r);
            check_model($sformatf("random_c%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
